quadrature_decoder: RTL and testbench

- Decodes a two-phase quadrature input pair (A/B) into a signed direction and a modulo-2^N position count.
- Input path: 2-flop synchronizer, then per-channel glitch filter, then transition decoder, then up/down position counter.
- Sits between an off-chip incremental encoder and the counting/display logic. Flags illegal double-edge transitions.

---
 rtl/quadrature_decoder_pkg.sv | 21 ++
 rtl/quadrature_decoder_if.sv | 22 ++
 rtl/quadrature_decoder_filter.sv | 56 +++++
 rtl/quadrature_decoder.sv | 98 +++++++++
 tb/tb_quadrature_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/quadrature_decoder_pkg.sv
// Shared definitions for the quadrature decoder: FSM states, Gray-order step
// table and default filter depth.
package quad_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int FILT_DEFAULT = 3;
  localparam int CNT_W        = 4;

  // Successor of each {a,b} pair when stepping up, packed by pair value:
  // 00->10, 01->00, 10->11, 11->01.
  localparam logic [7:0] UP_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};

  function automatic logic [1:0] up_next(input logic [1:0] ab);
    return UP_NEXT[{ab, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder-side and count-side signals of the quadrature decoder.
interface quadrature_decoder_if #(
  parameter int N = 8
);
  logic         a_in;
  logic         b_in;
  logic         clear;
  logic [N-1:0] count;
  logic         dir;
  logic         step;
  logic         err;

  modport master (
    output a_in, b_in, clear,
    input  count, dir, step, err
  );

  modport slave (
    input  a_in, b_in, clear,
    output count, dir, step, err
  );
endinterface

// File: rtl/quadrature_decoder_filter.sv
// One encoder channel: two-flop synchronizer followed by a stability filter
// that only accepts a level held for FILT consecutive cycles.
module glitch_filter
  import quad_pkg::*;
#(
  parameter int FILT = FILT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic init_mode,
  output logic level,
  output logic stable
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FILT);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // During INIT the level tracks sync2 directly and cnt measures how long the
  // whole pipeline has been quiet; in RUN cnt measures disagreement length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (init_mode) begin
      level <= sync2;
      if (sync2 != level || sync1 != sync2)
        cnt <= '0;
      else if (cnt != LIMIT)
        cnt <= cnt + 1'b1;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == LIMIT - 1'b1) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = init_mode && (cnt == LIMIT);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered channels feed a Gray-order transition
// decoder driving a wrapping up/down position count with a sticky error flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int N    = 8,
  parameter int FILT = FILT_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  quadrature_decoder_if.slave bus
);

  state_t       state;
  logic         init_mode;
  logic         a_lvl;
  logic         b_lvl;
  logic         a_stable;
  logic         b_stable;
  logic [1:0]   prev_ab;
  logic [1:0]   cur_ab;
  logic         is_up;
  logic         is_down;
  logic         is_bad;
  logic [N-1:0] count_q;
  logic         dir_q;
  logic         step_q;
  logic         err_q;

  assign init_mode = (state == ST_INIT);

  glitch_filter #(.FILT(FILT)) u_filt_a (
    .clk       (clk),
    .reset     (reset),
    .raw       (bus.a_in),
    .init_mode (init_mode),
    .level     (a_lvl),
    .stable    (a_stable)
  );

  glitch_filter #(.FILT(FILT)) u_filt_b (
    .clk       (clk),
    .reset     (reset),
    .raw       (bus.b_in),
    .init_mode (init_mode),
    .level     (b_lvl),
    .stable    (b_stable)
  );

  assign cur_ab = {a_lvl, b_lvl};

  // Any change that is neither the up successor nor predecessor moved both bits.
  always_comb begin
    is_up   = (up_next(prev_ab) == cur_ab);
    is_down = (up_next(cur_ab) == prev_ab);
    is_bad  = (prev_ab != cur_ab) && !is_up && !is_down;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      prev_ab <= 2'b00;
      count_q <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      step_q  <= 1'b0;
      if (state == ST_INIT) begin
        if (a_stable && b_stable)
          state <= ST_RUN;
      end else if (is_up) begin
        count_q <= count_q + 1'b1;
        dir_q   <= 1'b1;
        step_q  <= 1'b1;
      end else if (is_down) begin
        count_q <= count_q - 1'b1;
        dir_q   <= 1'b0;
        step_q  <= 1'b1;
      end else if (is_bad) begin
        err_q <= 1'b1;
      end
      // A step coinciding with clear is intentionally dropped.
      if (bus.clear) begin
        count_q <= '0;
        err_q   <= 1'b0;
        step_q  <= 1'b0;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with a sample-history reference model
// compared against the outputs every cycle.
module tb_quadrature_decoder;
  import quad_pkg::*;

  localparam int N    = 8;
  localparam int FILT = 3;
  localparam int HOLD = 8;
  localparam int MOD  = 1 << N;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   lat;
  int   nsteps;

  quadrature_decoder_if #(.N(N)) bus ();

  quadrature_decoder #(.N(N), .FILT(FILT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: raw input history, window-based acceptance, Gray distance.
  logic [15:0] ha, hb;
  logic        m_init, m_fa, m_fb, m_pa, m_pb, m_dir, m_step, m_err;
  int          m_count, m_steady, m_delta;

  function automatic int gray_pos(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic window_is(input logic [15:0] h, input logic v);
    for (int i = 1; i <= FILT; i++)
      if (h[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      ha = '0; hb = '0;
      m_init = 1'b1; m_fa = 1'b0; m_fb = 1'b0; m_pa = 1'b0; m_pb = 1'b0;
      m_count = 0; m_dir = 1'b1; m_step = 1'b0; m_err = 1'b0; m_steady = 0;
    end else begin
      m_step = 1'b0;
      if (!m_init && ({m_fa, m_fb} != {m_pa, m_pb})) begin
        m_delta = (gray_pos(m_fa, m_fb) - gray_pos(m_pa, m_pb) + 4) % 4;
        if (m_delta == 1) begin
          m_count = (m_count + 1) % MOD; m_dir = 1'b1; m_step = 1'b1;
        end else if (m_delta == 3) begin
          m_count = (m_count + MOD - 1) % MOD; m_dir = 1'b0; m_step = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (bus.clear) begin
        m_count = 0; m_err = 1'b0; m_step = 1'b0;
      end
      m_pa = m_fa; m_pb = m_fb;
      if (m_init) begin
        if (ha[1] == m_fa && hb[1] == m_fb && ha[0] == ha[1] && hb[0] == hb[1])
          m_steady++;
        else
          m_steady = 0;
        m_fa = ha[1]; m_fb = hb[1];
        if (m_steady >= FILT + 2) m_init = 1'b0;
      end else begin
        if (window_is(ha, ~m_fa)) m_fa = ~m_fa;
        if (window_is(hb, ~m_fb)) m_fb = ~m_fb;
      end
      ha = {ha[14:0], bus.a_in};
      hb = {hb[14:0], bus.b_in};
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check_output("model count", int'(bus.count), m_count);
    check_output("model dir", int'(bus.dir), int'(m_dir));
    check_output("model step", int'(bus.step), int'(m_step));
    check_output("model err", int'(bus.err), int'(m_err));
  end

  task automatic apply_stimulus(input logic a, input logic b, input int hold,
                                output int first, output int steps);
    @(negedge clk);
    bus.a_in = a;
    bus.b_in = b;
    first = -1;
    steps = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (bus.step) begin
        steps++;
        if (first < 0) first = i - 1;
      end
    end
  endtask

  task automatic idle_cycles(input int n, output int steps);
    steps = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.step) steps++;
    end
  endtask

  task automatic move(input logic a, input logic b, input int exp_count, input int exp_dir);
    int first, steps;
    apply_stimulus(a, b, HOLD, first, steps);
    check_output("step latency", first, 5);
    check_output("step pulses", steps, 1);
    check_output("count after move", int'(bus.count), exp_count);
    check_output("dir after move", int'(bus.dir), exp_dir);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.a_in  = 1'b1;
    bus.b_in  = 1'b1;
    bus.clear = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_cycles(12, nsteps);
    check_output("init steps", nsteps, 0);
    check_output("init count", int'(bus.count), 0);
    check_output("init err", int'(bus.err), 0);
    check_output("init state", int'(dut.state), int'(ST_RUN));

    move(1'b0, 1'b1, 1, 1);
    move(1'b0, 1'b0, 2, 1);
    pulse_clear();
    check_output("clear count", int'(bus.count), 0);

    move(1'b1, 1'b0, 1, 1);
    move(1'b1, 1'b1, 2, 1);
    move(1'b0, 1'b1, 3, 1);
    move(1'b0, 1'b0, 4, 1);
    pulse_clear();

    move(1'b0, 1'b1, 255, 0);
    move(1'b0, 1'b0, 0, 1);
    move(1'b0, 1'b1, 255, 0);

    @(negedge clk);
    bus.a_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.a_in = 1'b0;
    idle_cycles(HOLD, nsteps);
    check_output("glitch steps", nsteps, 0);
    check_output("glitch count", int'(bus.count), 255);
    check_output("glitch filtered a", int'(dut.u_filt_a.level), 0);

    apply_stimulus(1'b1, 1'b0, HOLD, lat, nsteps);
    check_output("double edge steps", nsteps, 0);
    check_output("double edge err", int'(bus.err), 1);
    check_output("double edge count", int'(bus.count), 255);
    check_output("double edge dir", int'(bus.dir), 0);
    pulse_clear();
    check_output("clear err", int'(bus.err), 0);
    check_output("clear count after err", int'(bus.count), 0);
    check_output("clear keeps dir", int'(bus.dir), 0);

    move(1'b1, 1'b1, 1, 1);
    move(1'b0, 1'b1, 2, 1);
    move(1'b0, 1'b0, 3, 1);
    move(1'b1, 1'b0, 4, 1);
    move(1'b1, 1'b1, 5, 1);
    move(1'b0, 1'b1, 6, 1);
    move(1'b0, 1'b0, 7, 1);

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("async reset count", int'(bus.count), 0);
    check_output("async reset err", int'(bus.err), 0);
    check_output("async reset dir", int'(bus.dir), 1);
    check_output("async reset step", int'(bus.step), 0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(12, nsteps);
    check_output("reinit steps", nsteps, 0);
    check_output("reinit count", int'(bus.count), 0);
    move(1'b1, 1'b0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
